// File: rtl/text_blitter.sv
// Glyph-string renderer: latches a string of character ids, fetches each glyph row
// from an external synchronous ROM and emits one plotted pixel per cycle.
module text_blitter #(
  parameter int GLYPH_W     = 8,
  parameter int GLYPH_H     = 8,
  parameter int ADVANCE     = 8,
  parameter int MAX_CHARS   = 8,
  parameter int CHAR_ID_W   = 5,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOUR_W    = 3,
  parameter int TRANSPARENT = 0,
  localparam int LEN_W      = $clog2(MAX_CHARS + 1),
  localparam int ROW_W      = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1,
  localparam int COL_W      = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1,
  localparam int CI_W       = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [X_W-1:0]                 base_x,
  input  logic [Y_W-1:0]                 base_y,
  input  logic [LEN_W-1:0]               length,
  input  logic [MAX_CHARS*CHAR_ID_W-1:0] chars,
  input  logic                           erase,
  input  logic [COLOUR_W-1:0]            fg_colour,
  output logic [CHAR_ID_W-1:0]           rom_char,
  output logic [ROW_W-1:0]               rom_row,
  input  logic [GLYPH_W-1:0]             rom_data,
  output logic                           plot,
  output logic [X_W-1:0]                 draw_x,
  output logic [Y_W-1:0]                 draw_y,
  output logic [COLOUR_W-1:0]            colour,
  output logic                           busy,
  output logic                           done,
  output logic [X_W-1:0]                 next_x
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_DRAW, S_FIN} state_t;

  state_t                         state_r, state_nxt_s;
  logic [MAX_CHARS*CHAR_ID_W-1:0] chars_r;
  logic [LEN_W-1:0]               len_r, len_in_s;
  logic [Y_W-1:0]                 base_y_r;
  logic [X_W-1:0]                 cell_x_r;
  logic                           erase_r;
  logic [COLOUR_W-1:0]            fg_r;
  logic [CI_W-1:0]                ci_r;
  logic [ROW_W-1:0]               row_r;
  logic [COL_W-1:0]               col_r, col_inc_s;
  logic [GLYPH_W-1:0]             shift_r;
  logic                           last_col_s, last_row_s, last_char_s;
  logic                           pix_bit_s, pix_plot_s;
  logic [COLOUR_W-1:0]            pix_colour_s;

  function automatic logic [CHAR_ID_W-1:0] char_at(input logic [MAX_CHARS*CHAR_ID_W-1:0] v,
                                                   input int idx);
    return v[idx*CHAR_ID_W +: CHAR_ID_W];
  endfunction

  // Per-cycle decode: clamped length, counter wrap flags and the pixel being emitted next.
  always_comb begin
    len_in_s    = (length > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : length;
    last_col_s  = (col_r == COL_W'(GLYPH_W - 1));
    last_row_s  = (row_r == ROW_W'(GLYPH_H - 1));
    last_char_s = ((32'(ci_r) + 32'd1) == 32'(len_r));
    col_inc_s   = col_r + 1'b1;
    // The first pixel of a row comes straight off rom_data; later ones from the shifter.
    if (state_r == S_LOAD) begin
      pix_bit_s = rom_data[GLYPH_W-1];
    end else begin
      pix_bit_s = shift_r[GLYPH_W-1];
    end
    pix_plot_s = erase_r | pix_bit_s | (TRANSPARENT == 0);
    if (!erase_r && pix_bit_s) begin
      pix_colour_s = fg_r;
    end else begin
      pix_colour_s = {COLOUR_W{1'b0}};
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = (len_in_s != {LEN_W{1'b0}}) ? S_FETCH : S_FIN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FETCH: state_nxt_s = S_LOAD;
      S_LOAD:  state_nxt_s = S_DRAW;
      S_DRAW: begin
        if (last_col_s) begin
          state_nxt_s = (last_row_s && last_char_s) ? S_FIN : S_FETCH;
        end else begin
          state_nxt_s = S_DRAW;
        end
      end
      S_FIN:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= S_IDLE;
    else         state_r <= state_nxt_s;
  end

  // Datapath: latched request, counters, ROM address and registered pixel outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chars_r  <= {(MAX_CHARS*CHAR_ID_W){1'b0}};
      len_r    <= {LEN_W{1'b0}};
      base_y_r <= {Y_W{1'b0}};
      cell_x_r <= {X_W{1'b0}};
      erase_r  <= 1'b0;
      fg_r     <= {COLOUR_W{1'b0}};
      ci_r     <= {CI_W{1'b0}};
      row_r    <= {ROW_W{1'b0}};
      col_r    <= {COL_W{1'b0}};
      shift_r  <= {GLYPH_W{1'b0}};
      rom_char <= {CHAR_ID_W{1'b0}};
      rom_row  <= {ROW_W{1'b0}};
      plot     <= 1'b0;
      draw_x   <= {X_W{1'b0}};
      draw_y   <= {Y_W{1'b0}};
      colour   <= {COLOUR_W{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      next_x   <= {X_W{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          plot   <= 1'b0;
          colour <= {COLOUR_W{1'b0}};
          if (start) begin
            chars_r  <= chars;
            len_r    <= len_in_s;
            base_y_r <= base_y;
            cell_x_r <= base_x;
            erase_r  <= erase;
            fg_r     <= fg_colour;
            ci_r     <= {CI_W{1'b0}};
            row_r    <= {ROW_W{1'b0}};
            col_r    <= {COL_W{1'b0}};
            next_x   <= base_x + X_W'(32'(len_in_s) * ADVANCE);
            rom_char <= char_at(chars, 0);
            rom_row  <= {ROW_W{1'b0}};
            busy     <= (len_in_s != {LEN_W{1'b0}});
            done     <= (len_in_s == {LEN_W{1'b0}});
          end
        end
        S_FETCH: plot <= 1'b0;
        S_LOAD: begin
          shift_r <= rom_data << 1;
          col_r   <= {COL_W{1'b0}};
          plot    <= pix_plot_s;
          colour  <= pix_colour_s;
          draw_x  <= cell_x_r;
          draw_y  <= base_y_r + Y_W'(row_r);
        end
        S_DRAW: begin
          if (!last_col_s) begin
            shift_r <= shift_r << 1;
            col_r   <= col_inc_s;
            plot    <= pix_plot_s;
            colour  <= pix_colour_s;
            draw_x  <= cell_x_r + X_W'(col_inc_s);
          end else begin
            plot   <= 1'b0;
            colour <= {COLOUR_W{1'b0}};
            if (!last_row_s) begin
              row_r   <= row_r + 1'b1;
              rom_row <= row_r + 1'b1;
            end else if (!last_char_s) begin
              ci_r     <= ci_r + 1'b1;
              row_r    <= {ROW_W{1'b0}};
              rom_row  <= {ROW_W{1'b0}};
              rom_char <= char_at(chars_r, int'(ci_r) + 1);
              cell_x_r <= cell_x_r + X_W'(ADVANCE);
            end else begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        S_FIN: plot <= 1'b0;
        default: begin
          plot <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_blitter.sv
// Scoreboard bench: two instances (opaque and transparent) share stimulus; expected
// pixels are queued at request time and popped as each DUT plots.
module tb_text_blitter;
  localparam int GW = 8, GH = 8, ADV = 8, MC = 8, CW = 5, XW = 8, YW = 7, COLW = 3, LW = 4;

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, erase = 1'b0;
  logic [XW-1:0]    base_x = '0;
  logic [YW-1:0]    base_y = '0;
  logic [LW-1:0]    length = '0;
  logic [MC*CW-1:0] chars = '0;
  logic [COLW-1:0]  fg_colour = '0;
  bit               rom_x = 1'b0;

  logic [CW-1:0]   rom_char0, rom_char1;
  logic [2:0]      rom_row0, rom_row1;
  logic [GW-1:0]   rom_data0, rom_data1;
  logic            plot0, plot1, busy0, busy1, done0, done1;
  logic [XW-1:0]   draw_x0, draw_x1, next_x0, next_x1;
  logic [YW-1:0]   draw_y0, draw_y1;
  logic [COLW-1:0] colour0, colour1;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int n_plot0 = 0, n_plot1 = 0, n_busy = 0, n_done0 = 0, n_done1 = 0, done0_cyc = 0, done1_cyc = 0;
  logic [17:0] q0[$], q1[$];

  text_blitter #(.TRANSPARENT(0)) u0 (
    .clk(clk), .resetn(resetn), .start(start), .base_x(base_x), .base_y(base_y), .length(length),
    .chars(chars), .erase(erase), .fg_colour(fg_colour), .rom_char(rom_char0), .rom_row(rom_row0),
    .rom_data(rom_data0), .plot(plot0), .draw_x(draw_x0), .draw_y(draw_y0), .colour(colour0),
    .busy(busy0), .done(done0), .next_x(next_x0));

  text_blitter #(.TRANSPARENT(1)) u1 (
    .clk(clk), .resetn(resetn), .start(start), .base_x(base_x), .base_y(base_y), .length(length),
    .chars(chars), .erase(erase), .fg_colour(fg_colour), .rom_char(rom_char1), .rom_row(rom_row1),
    .rom_data(rom_data1), .plot(plot1), .draw_x(draw_x1), .draw_y(draw_y1), .colour(colour1),
    .busy(busy1), .done(done1), .next_x(next_x1));

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [4:0] c, input logic [2:0] r);
    logic [7:0] t;
    t = {3'b000, c} * 8'd29 + {5'b00000, r} * 8'd13;
    return (c == 5'd3) ? 8'hA5 : (t ^ 8'h3C);
  endfunction

  // Synchronous glyph ROM models, one per instance.
  always @(posedge clk) begin
    rom_data0 <= rom_x ? 8'hxx : glyph(rom_char0, rom_row0);
    rom_data1 <= rom_x ? 8'hxx : glyph(rom_char1, rom_row1);
    cyc       <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboards on every plot and tallies busy/done.
  initial begin
    forever begin
      @(negedge clk);
      if (plot0) begin
        n_plot0++;
        if (q0.size() == 0) check_eq("plot0_extra", 32'd1, 32'd0);
        else check_eq("pix0", {14'd0, draw_x0, draw_y0, colour0}, {14'd0, q0.pop_front()});
      end
      if (plot1) begin
        n_plot1++;
        if (q1.size() == 0) check_eq("plot1_extra", 32'd1, 32'd0);
        else check_eq("pix1", {14'd0, draw_x1, draw_y1, colour1}, {14'd0, q1.pop_front()});
      end
      if (busy0) n_busy++;
      if (done0) begin n_done0++; done0_cyc = cyc; end
      if (done1) begin n_done1++; done1_cyc = cyc; end
    end
  end

  task automatic push_exp(input logic [7:0] bx, input logic [6:0] by, input int l,
                          input logic [MC*CW-1:0] ch, input bit er, input logic [2:0] fgc,
                          output int n1);
    logic [7:0] g, x;
    logic [6:0] y;
    logic [2:0] c;
    logic       bt;
    n1 = 0;
    for (int ci = 0; ci < l; ci++)
      for (int r = 0; r < GH; r++)
        for (int col = 0; col < GW; col++) begin
          g  = glyph(ch[ci*CW +: CW], 3'(r));
          bt = g[GW-1-col];
          x  = bx + 8'(ci * ADV + col);
          y  = by + 7'(r);
          c  = (!er && bt) ? fgc : 3'd0;
          q0.push_back({x, y, c});
          if (er || bt) begin
            q1.push_back({x, y, c});
            n1++;
          end
        end
  endtask

  task automatic start_req(input logic [7:0] bx, input logic [6:0] by, input logic [3:0] len,
                           input logic [MC*CW-1:0] ch, input bit er, input logic [2:0] fgc,
                           input bit rx, output int t0);
    @(negedge clk);
    base_x = bx; base_y = by; length = len; chars = ch; erase = er; fg_colour = fgc; rom_x = rx;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    // Inputs are don't-care once accepted; scramble them.
    base_x = 8'($urandom); base_y = 7'($urandom); length = 4'($urandom);
    chars = {$urandom, 8'($urandom)}; erase = ~er; fg_colour = 3'($urandom);
  endtask

  task automatic render(input string nm, input logic [7:0] bx, input logic [6:0] by,
                        input logic [3:0] len, input logic [MC*CW-1:0] ch, input bit er,
                        input logic [2:0] fgc, input bit rx);
    int l, n1, t0, p0, p1, b, d0, d1;
    bit ok;
    l = (len > 4'd8) ? 8 : int'(len);
    push_exp(bx, by, l, ch, er, fgc, n1);
    p0 = n_plot0; p1 = n_plot1; b = n_busy; d0 = n_done0; d1 = n_done1;
    start_req(bx, by, len, ch, er, fgc, rx, t0);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done0) begin ok = 1'b1; break; end
    end
    check_eq({nm, "_timeout"}, 32'(ok), 32'd1);
    @(negedge clk);
    #1;
    check_eq({nm, "_plots0"}, n_plot0 - p0, l * GW * GH);
    check_eq({nm, "_plots1"}, n_plot1 - p1, n1);
    check_eq({nm, "_busy"}, n_busy - b, l * GH * (GW + 2));
    check_eq({nm, "_done0"}, n_done0 - d0, 1);
    check_eq({nm, "_done1"}, n_done1 - d1, 1);
    check_eq({nm, "_done_cyc"}, done0_cyc - t0, l * GH * (GW + 2));
    check_eq({nm, "_done_cyc1"}, done1_cyc, done0_cyc);
    check_eq({nm, "_next_x"}, 32'(next_x0), 32'(8'(bx + 8'(l * ADV))));
    check_eq({nm, "_next_x1"}, 32'(next_x1), 32'(8'(bx + 8'(l * ADV))));
    check_eq({nm, "_q_empty"}, q0.size() + q1.size(), 0);
    rom_x = 1'b0;
  endtask

  initial begin
    int t0, n1, p0, d0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outs", {plot0, busy0, done0, plot1, busy1, done1}, 6'd0);
    check_eq("rst_pos", {next_x0, draw_x0, draw_y0, colour0}, 26'd0);
    check_eq("rst_rom", {rom_char0, rom_row0}, 8'd0);
    @(negedge clk);
    resetn = 1'b1;

    render("basic", 8'd10, 7'd20, 4'd1, 40'd3, 1'b0, 3'd5, 1'b0);
    render("erase", 8'd0, 7'd0, 4'd3, 40'h12345, 1'b1, 3'd6, 1'b1);
    render("len0", 8'd77, 7'd5, 4'd0, 40'h1, 1'b0, 3'd7, 1'b0);
    render("clamp", 8'd3, 7'd40, 4'd15, 40'h8_F3A9_61C7, 1'b0, 3'd2, 1'b0);
    render("wrap", 8'd250, 7'd125, 4'd2, 40'h0_0000_0083, 1'b0, 3'd4, 1'b0);

    // Abort in row 3 of char 1 and confirm nothing follows.
    push_exp(8'd30, 7'd60, 2, 40'h0_0000_00A6, 1'b0, 3'd3, n1);
    start_req(8'd30, 7'd60, 4'd2, 40'h0_0000_00A6, 1'b0, 3'd3, 1'b0, t0);
    repeat (114) @(posedge clk);
    #2;
    check_eq("mid_plot", 32'(plot0), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("abort_outs", {plot0, busy0, done0, plot1, busy1, done1}, 6'd0);
    q0.delete();
    q1.delete();
    p0 = n_plot0; d0 = n_done0;
    repeat (4) @(negedge clk);
    #1;
    check_eq("abort_quiet", (n_plot0 - p0) + (n_done0 - d0), 0);
    resetn = 1'b1;
    render("after_rst", 8'd5, 7'd100, 4'd1, 40'h0_0000_0007, 1'b0, 3'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
